// File: rtl/audio_pkg.sv
// Shared types and widths for the stereo PDM capture path.
package audio_pkg;

  localparam int PCM_W   = 16;
  localparam int FRAME_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with flush and occupancy level.
module audio_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          wr_ok, rd_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == LW'(DEPTH));
  assign level = cnt_q;

  // A pop on a full FIFO frees the slot the same push lands in.
  assign wr_ok = push & ~flush & (~full | pop);
  assign rd_ok = pop & ~flush & ~empty;

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + LW'(wr_ok) - LW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/audio_capture_ctrl.sv
// Stereo PDM capture sequencer: strobe gating, CIC warmup discard,
// L/R frame pairing into a buffered valid/ready stream.
module audio_capture_ctrl
  import audio_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WARMUP = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mute,
  input  logic                     stb_left,
  input  logic                     stb_right,
  input  logic                     stb_pcm,
  input  logic [PCM_W-1:0]         pcm_l,
  input  logic [PCM_W-1:0]         pcm_r,
  output logic                     stb_smp_l,
  output logic                     stb_smp_r,
  output logic                     pdm_en,
  output logic                     m_valid,
  output logic [FRAME_W-1:0]       m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(WARMUP) + 1;

  cap_state_e   state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic         cap_q, cap_d;
  logic         pdm_en_q, pdm_en_d;
  logic         ovf_q, ovf_d;
  logic         push, flush, drop;
  logic         full, empty;
  logic [FRAME_W-1:0] push_data;

  logic active;
  assign active = (state_q != ST_IDLE);

  // Integrators freeze outside capture and while reset is held.
  assign stb_smp_l = stb_left  & active & rst_n;
  assign stb_smp_r = stb_right & active & rst_n;

  assign push_data = mute ? '0 : {pcm_l, pcm_r};

  always_comb begin
    cap_d   = stb_pcm;
    state_d = state_q;
    warm_d  = warm_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_WARMUP;
          warm_d  = '0;
          flush   = 1'b1;
        end
      end
      ST_WARMUP: begin
        if (cap_q) begin
          if (warm_q == WW'(WARMUP - 1)) state_d = ST_RUN;
          else warm_d = warm_q + WW'(1);
        end
      end
      ST_RUN: push = cap_q;
      default: state_d = ST_IDLE;
    endcase
    if (!en) state_d = ST_IDLE;
    pdm_en_d = (state_d != ST_IDLE);
  end

  assign drop  = push & full & ~m_ready;
  assign ovf_d = (ovf_q & ~ovf_clr) | drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      warm_q   <= '0;
      cap_q    <= 1'b0;
      pdm_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      cap_q    <= cap_d;
      pdm_en_q <= pdm_en_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pdm_en  = pdm_en_q;
  assign ovf     = ovf_q;
  assign m_valid = ~empty;

  audio_frame_fifo #(
    .DEPTH (DEPTH),
    .W     (FRAME_W),
    .LW    (LW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (m_ready),
    .pop_data  (m_data),
    .empty     (empty),
    .full      (full),
    .level     (level)
  );

endmodule

// File: tb/tb_audio_capture_ctrl.sv
// Directed self-checking bench for audio_capture_ctrl (DEPTH=4, WARMUP=8).
module tb_audio_capture_ctrl;

  logic        clk = 0;
  logic        rst_n, en, mute;
  logic        stb_left, stb_right, stb_pcm;
  logic [15:0] pcm_l, pcm_r;
  logic        stb_smp_l, stb_smp_r, pdm_en;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic [2:0]  level;
  logic        ovf, ovf_clr;

  int n_chk = 0;
  int n_fail = 0;

  audio_capture_ctrl #(.DEPTH(4), .WARMUP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mute      (mute),
    .stb_left  (stb_left),
    .stb_right (stb_right),
    .stb_pcm   (stb_pcm),
    .pcm_l     (pcm_l),
    .pcm_r     (pcm_r),
    .stb_smp_l (stb_smp_l),
    .stb_smp_r (stb_smp_r),
    .pdm_en    (pdm_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    pcm_l = l;
    pcm_r = r;
    stb_pcm = 1;
    cyc();
    stb_pcm = 0;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; mute = 0; stb_left = 1; stb_right = 1;
    stb_pcm = 0; pcm_l = 0; pcm_r = 0; m_ready = 0; ovf_clr = 0;
    cyc(); cyc();
    n_chk++;
    if ({pdm_en, m_valid, ovf} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {pdm_en, m_valid, ovf});
    end
    n_chk++;
    if (level !== 3'd0 || m_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_level: got %0d/%h expected 0/0", level, m_data);
    end
    n_chk++;
    if ({stb_smp_l, stb_smp_r} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_stb: got %b expected 00", {stb_smp_l, stb_smp_r});
    end
    rst_n = 1;
    cyc();
    n_chk++;
    if ({stb_smp_l, stb_smp_r} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_stb: got %b expected 00", {stb_smp_l, stb_smp_r});
    end
    stb_left = 0; stb_right = 0;
  endtask

  task automatic test_warmup();
    en = 1;
    cyc();
    n_chk++;
    if (pdm_en !== 1'b1) begin
      n_fail++;
      $display("FAIL warm_pdm_en: got %b expected 1", pdm_en);
    end
    stb_left = 1; stb_right = 1;
    #1;
    n_chk++;
    if ({stb_smp_l, stb_smp_r} !== 2'b11) begin
      n_fail++;
      $display("FAIL warm_stb: got %b expected 11", {stb_smp_l, stb_smp_r});
    end
    stb_left = 0; stb_right = 0;
    for (int i = 0; i < 8; i++) frame(16'h1234, 16'hABCD);
    n_chk++;
    if (level !== 3'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL warm_discard: got level %0d valid %b expected 0 0", level, m_valid);
    end
    stb_pcm = 1;
    cyc();
    stb_pcm = 0;
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL warm_lat1: got %b expected 0", m_valid);
    end
    cyc();
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 32'h1234ABCD || level !== 3'd1) begin
      n_fail++;
      $display("FAIL warm_first: got %b %h %0d expected 1 1234abcd 1", m_valid, m_data, level);
    end
    m_ready = 1;
    cyc();
    m_ready = 0;
    n_chk++;
    if (level !== 3'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL warm_pop: got level %0d valid %b expected 0 0", level, m_valid);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) frame(16'(i + 1), 16'(i + 256));
    n_chk++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_fill: got level %0d ovf %b expected 4 0", level, ovf);
    end
    frame(16'd5, 16'd260);
    n_chk++;
    if (level !== 3'd4 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got level %0d ovf %b expected 4 1", level, ovf);
    end
    ovf_clr = 1;
    frame(16'd6, 16'd261);
    ovf_clr = 0;
    n_chk++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b expected 1", ovf);
    end
    ovf_clr = 1;
    cyc();
    ovf_clr = 0;
    n_chk++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got %b expected 0", ovf);
    end
    m_ready = 1;
    for (int k = 0; k < 4; k++) begin
      exp = {16'(k + 1), 16'(k + 256)};
      n_chk++;
      if (m_data !== exp || m_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_order%0d: got %h expected %h", k, m_data, exp);
      end
      cyc();
    end
    m_ready = 0;
    n_chk++;
    if (level !== 3'd0) begin
      n_fail++;
      $display("FAIL ovf_drain: got %0d expected 0", level);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) frame(16'hA000 + 16'(i), 16'hB000 + 16'(i));
    pcm_l = 16'hA004; pcm_r = 16'hB004;
    stb_pcm = 1;
    cyc();
    stb_pcm = 0;
    m_ready = 1;
    cyc();
    m_ready = 0;
    n_chk++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_level: got level %0d ovf %b expected 4 0", level, ovf);
    end
    m_ready = 1;
    for (int k = 1; k < 5; k++) begin
      exp = {16'hA000 + 16'(k), 16'hB000 + 16'(k)};
      n_chk++;
      if (m_data !== exp) begin
        n_fail++;
        $display("FAIL fpp_order%0d: got %h expected %h", k, m_data, exp);
      end
      cyc();
    end
    m_ready = 0;
  endtask

  task automatic test_mute_disable();
    mute = 1;
    frame(16'h5555, 16'h6666);
    mute = 0;
    n_chk++;
    if (level !== 3'd1 || m_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mute_data: got %0d %h expected 1 0", level, m_data);
    end
    frame(16'h7777, 16'h8888);
    pcm_l = 16'h9999; pcm_r = 16'hAAAA;
    stb_pcm = 1;
    cyc();
    stb_pcm = 0;
    en = 0;
    cyc();
    n_chk++;
    if (level !== 3'd3 || pdm_en !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_pending: got level %0d pdm_en %b expected 3 0", level, pdm_en);
    end
    stb_left = 1;
    #1;
    n_chk++;
    if (stb_smp_l !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_stb: got %b expected 0", stb_smp_l);
    end
    stb_left = 0;
    frame(16'h1111, 16'h2222);
    frame(16'h1111, 16'h2222);
    n_chk++;
    if (level !== 3'd3) begin
      n_fail++;
      $display("FAIL dis_nopush: got %0d expected 3", level);
    end
    m_ready = 1;
    n_chk++;
    if (m_data !== 32'h0) begin
      n_fail++;
      $display("FAIL drain0: got %h expected 0", m_data);
    end
    cyc();
    n_chk++;
    if (m_data !== 32'h77778888) begin
      n_fail++;
      $display("FAIL drain1: got %h expected 77778888", m_data);
    end
    cyc();
    m_ready = 0;
    n_chk++;
    if (m_data !== 32'h9999AAAA || level !== 3'd1) begin
      n_fail++;
      $display("FAIL drain2: got %h %0d expected 9999aaaa 1", m_data, level);
    end
    en = 1;
    cyc();
    n_chk++;
    if (level !== 3'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reen_flush: got %0d %b expected 0 0", level, m_valid);
    end
    for (int i = 0; i < 8; i++) frame(16'h0102, 16'h0304);
    n_chk++;
    if (level !== 3'd0) begin
      n_fail++;
      $display("FAIL reen_discard: got %0d expected 0", level);
    end
    frame(16'h0506, 16'h0708);
    n_chk++;
    if (level !== 3'd1 || m_data !== 32'h05060708) begin
      n_fail++;
      $display("FAIL reen_first: got %0d %h expected 1 05060708", level, m_data);
    end
  endtask

  task automatic test_reset_mid();
    frame(16'h0001, 16'h0002);
    frame(16'h0003, 16'h0004);
    n_chk++;
    if (level !== 3'd3) begin
      n_fail++;
      $display("FAIL rmid_pre: got %0d expected 3", level);
    end
    rst_n = 0;
    stb_left = 1;
    #1;
    n_chk++;
    if (stb_smp_l !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_stb: got %b expected 0", stb_smp_l);
    end
    cyc();
    n_chk++;
    if (level !== 3'd0 || m_valid !== 1'b0 || pdm_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_state: got %0d %b %b expected 0 0 0", level, m_valid, pdm_en);
    end
    en = 0;
    rst_n = 1;
    cyc();
    n_chk++;
    if (stb_smp_l !== 1'b0 || pdm_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_idle: got %b %b expected 0 0", stb_smp_l, pdm_en);
    end
    stb_left = 0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_overflow();
    test_full_push_pop();
    test_mute_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
